regfile_wb_queue: RTL and testbench

Write-back queue sitting directly upstream of the 32×32-bit register file's single write port (`wn`, `d`, `we`). It accepts results from two producers, the ALU (port A) and the load unit (port B), through valid/ready handshakes and buffers them in program order in a small FIFO. It drains one write per cycle into the register file. An optional lookup port lets operand fetch see pending values before they are written.

---
 rtl/regfile_wb_queue.sv | 162 ++++++++++++++++
 tb/tb_regfile_wb_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-back queue in front of the 32x32 register file
// write port. Two producers (A = ALU, B = load unit) push {wn, d} results
// in program order (A older than B when both are accepted together);
// the queue drains one register-file write per cycle from its head.
//
// Optional feature: define WB_FWD_EN to build the lookup port (lk_n ->
// lk_hit/lk_d) that forwards the youngest pending value for a register.
// Without WB_FWD_EN, lk_hit and lk_d are tied to 0 and lk_n is ignored.
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [4:0]               a_wn,
  input  logic [31:0]              a_d,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_wn,
  input  logic [31:0]              b_d,
  output logic                     we,
  output logic [4:0]               wn,
  output logic [31:0]              d,
  output logic [$clog2(DEPTH):0]   pending,
  input  logic [4:0]               lk_n,
  output logic                     lk_hit,
  output logic [31:0]              lk_d
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // FIFO storage and control state
  logic [4:0]    mem_wn_r [DEPTH];
  logic [31:0]   mem_d_r  [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  // Handshake / update terms
  logic [CW-1:0] free_s;
  logic          a_fire_s;
  logic          b_fire_s;
  logic          a_push_s;
  logic          b_push_s;
  logic          pop_s;
  logic [1:0]    push_cnt_s;
  logic [AW-1:0] b_slot_s;
  logic [AW-1:0] wr_ptr_next_s;
  logic [AW-1:0] rd_ptr_next_s;
  logic [CW-1:0] count_next_s;

  // Free slots and ready rules; free deliberately ignores the same-cycle
  // drain so the readies depend only on registered count and a_valid.
  always_comb begin
    free_s  = CW'(DEPTH) - count_r;
    a_ready = (free_s >= CW'(1));
    b_ready = (free_s >= CW'(2)) || ((free_s >= CW'(1)) && !a_valid);
  end

  // Accept/enqueue decisions: r0 destinations complete the handshake but
  // are dropped, since r0 is never written.
  always_comb begin
    a_fire_s   = a_valid && a_ready;
    b_fire_s   = b_valid && b_ready;
    a_push_s   = a_fire_s && (a_wn != 5'd0);
    b_push_s   = b_fire_s && (b_wn != 5'd0);
    pop_s      = (count_r != CW'(0));
    push_cnt_s = {1'b0, a_push_s} + {1'b0, b_push_s};
  end

  // Slot for B: directly after A's slot when A also enqueues this cycle
  always_comb begin
    if (a_push_s) begin
      b_slot_s = wr_ptr_r + AW'(1);
    end else begin
      b_slot_s = wr_ptr_r;
    end
  end

  // Next-state arithmetic for pointers (wrap modulo DEPTH) and count
  always_comb begin
    wr_ptr_next_s = wr_ptr_r + AW'(push_cnt_s);
    rd_ptr_next_s = rd_ptr_r + AW'(pop_s);
    count_next_s  = count_r + CW'(push_cnt_s) - CW'(pop_s);
  end

  // Pointer and count registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_next_s;
      wr_ptr_r <= wr_ptr_next_s;
      count_r  <= count_next_s;
    end
  end

  // Entry storage writes; contents need no reset because the count gates use
  always_ff @(posedge clk) begin
    if (clr) begin
      // Pushes in a clear cycle are discarded along with the pointers.
    end else begin
      if (a_push_s) begin
        mem_wn_r[wr_ptr_r] <= a_wn;
        mem_d_r[wr_ptr_r]  <= a_d;
      end
      if (b_push_s) begin
        mem_wn_r[b_slot_s] <= b_wn;
        mem_d_r[b_slot_s]  <= b_d;
      end
    end
  end

  // Drain port driven only from registered state (no bypass from inputs)
  always_comb begin
    we      = (count_r != CW'(0));
    pending = count_r;
    if (we) begin
      wn = mem_wn_r[rd_ptr_r];
      d  = mem_d_r[rd_ptr_r];
    end else begin
      wn = 5'd0;
      d  = 32'd0;
    end
  end

`ifdef WB_FWD_EN
  logic [AW-1:0] lk_idx_s;

  // Lookup: scan oldest to youngest so the last match (youngest) wins;
  // the head entry being written this cycle still counts.
  always_comb begin
    lk_hit   = 1'b0;
    lk_d     = 32'd0;
    lk_idx_s = rd_ptr_r;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx_s = rd_ptr_r + AW'(i);
      if ((CW'(i) < count_r) && (lk_n != 5'd0) && (mem_wn_r[lk_idx_s] == lk_n)) begin
        lk_hit = 1'b1;
        lk_d   = mem_d_r[lk_idx_s];
      end else begin
        lk_hit = lk_hit;
        lk_d   = lk_d;
      end
    end
  end
`else
  logic unused_lk_s;

  // Lookup disabled: outputs tied off, lookup number ignored
  always_comb begin
    unused_lk_s = ^lk_n;
    lk_hit      = 1'b0;
    lk_d        = 32'd0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever we=1.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_wn, b_wn;
  logic [31:0] a_d, b_d;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;
  logic [2:0]  pending;
  logic [4:0]  lk_n;
  logic        lk_hit;
  logic [31:0] lk_d;

  int checks = 0;
  int failures = 0;
  int model_cnt = 0;
  bit mon_en = 1'b0;
  logic [36:0] exp_q[$];

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr),
    .a_valid(a_valid), .a_ready(a_ready), .a_wn(a_wn), .a_d(a_d),
    .b_valid(b_valid), .b_ready(b_ready), .b_wn(b_wn), .b_d(b_d),
    .we(we), .wn(wn), .d(d), .pending(pending),
    .lk_n(lk_n), .lk_hit(lk_hit), .lk_d(lk_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every drained write must match the oldest expected entry
  always @(negedge clk) begin
    if (mon_en && we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL drain_unexpected: got wn=%0d d=0x%08h expected no write", wn, d);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("drain_wn", {27'd0, wn}, {27'd0, e[36:32]});
        check("drain_d", d, e[31:0]);
      end
    end
  end

  // One cycle of stimulus; ready/pending expectations come from model_cnt
  task automatic send(input logic av, input logic [4:0] awn, input logic [31:0] ad,
                      input logic bv, input logic [4:0] bwn, input logic [31:0] bd,
                      output logic a_acc, output logic b_acc);
    int free;
    int pushes;
    logic exp_a, exp_b;
    @(negedge clk);
    a_valid = av; a_wn = awn; a_d = ad;
    b_valid = bv; b_wn = bwn; b_d = bd;
    #1;
    free  = DEPTH - model_cnt;
    exp_a = (free >= 1);
    exp_b = (free >= 2) || ((free >= 1) && !av);
    check("pending", {29'd0, pending}, model_cnt);
    check("pending_max", {31'd0, (pending <= 3'd4)}, 32'd1);
    check("a_ready", {31'd0, a_ready}, {31'd0, exp_a});
    check("b_ready", {31'd0, b_ready}, {31'd0, exp_b});
    check("we_no_bypass", {31'd0, we}, {31'd0, (model_cnt != 0)});
    a_acc = av && exp_a;
    b_acc = bv && exp_b;
    pushes = 0;
    if (a_acc && awn != 5'd0) begin exp_q.push_back({awn, ad}); pushes++; end
    if (b_acc && bwn != 5'd0) begin exp_q.push_back({bwn, bd}); pushes++; end
    model_cnt = model_cnt + pushes - ((model_cnt != 0) ? 1 : 0);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic x, y;
    for (int i = 0; i < n; i++) send(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, x, y);
  endtask

  // Lookup probe between edges; expectations depend on build option
  task automatic lk_probe(input logic [4:0] n, input logic hit_fwd, input logic [31:0] d_fwd);
    lk_n = n;
    #1;
`ifdef WB_FWD_EN
    check("lk_hit", {31'd0, lk_hit}, {31'd0, hit_fwd});
    check("lk_d", lk_d, d_fwd);
`else
    check("lk_hit_off", {31'd0, lk_hit}, 32'd0);
    check("lk_d_off", lk_d, 32'd0);
`endif
    lk_n = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic aa, ba;
    int ka, kb;
    // Reset with both producers valid: nothing may be enqueued
    clr = 1'b1; lk_n = 5'd0;
    a_valid = 1'b1; a_wn = 5'd9;  a_d = 32'h1111_1111;
    b_valid = 1'b1; b_wn = 5'd10; b_d = 32'h2222_2222;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_wn", {27'd0, wn}, 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_pending", {29'd0, pending}, 32'd0);
    check("rst_a_ready", {31'd0, a_ready}, 32'd1);
    check("rst_b_ready", {31'd0, b_ready}, 32'd1);
    check("rst_lk_hit", {31'd0, lk_hit}, 32'd0);
    check("rst_lk_d", lk_d, 32'd0);
    mon_en = 1'b1;

    // Single write: visible the cycle after acceptance, gone one edge later
    send(1'b1, 5'd5, 32'hffff_0000, 1'b0, 5'd0, 32'd0, aa, ba);
    check("single_we", {31'd0, we}, 32'd1);
    check("single_wn", {27'd0, wn}, 32'd5);
    check("single_d", d, 32'hffff_0000);
    check("single_pending", {29'd0, pending}, 32'd1);
    idle(1);
    check("single_pending_after", {29'd0, pending}, 32'd0);
    check("single_we_after", {31'd0, we}, 32'd0);

    // Ordering: A then B to the same register, same cycle
    send(1'b1, 5'd3, 32'd1, 1'b1, 5'd3, 32'd2, aa, ba);
    check("order_pending", {29'd0, pending}, 32'd2);
    check("order_head_d", d, 32'd1);
    idle(3);

    // r0 discard: handshake completes, nothing enqueued
    send(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'd0, aa, ba);
    check("r0_accepted", {31'd0, aa}, 32'd1);
    check("r0_pending", {29'd0, pending}, 32'd0);
    check("r0_we", {31'd0, we}, 32'd0);
    // B to r0 alongside a real A write
    send(1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd0, 32'hdead_beef, aa, ba);
    check("r0b_pending", {29'd0, pending}, 32'd1);
    idle(2);

    // Backpressure: A+B pairs, A idles every 4th cycle so B can get through
    ka = 0; kb = 0;
    for (int i = 0; i < 20; i++) begin
      send((i % 4) != 3, 5'((ka % 31) + 1), 32'ha000_0000 + ka,
           1'b1, 5'(((kb + 7) % 31) + 1), 32'hb000_0000 + kb, aa, ba);
      if (aa) ka++;
      if (ba) kb++;
    end
    idle(6);
    check("bp_b_progress", {31'd0, (kb > 2)}, 32'd1);

    // Mid-traffic reset discards pending entries
    send(1'b1, 5'd11, 32'h0000_00b1, 1'b1, 5'd12, 32'h0000_00b2, aa, ba);
    @(negedge clk);
    #1;
    clr = 1'b1; a_valid = 1'b1; a_wn = 5'd13; a_d = 32'h0000_00b3;
    @(posedge clk);
    #1;
    clr = 1'b0; a_valid = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    check("clr_pending", {29'd0, pending}, 32'd0);
    check("clr_we", {31'd0, we}, 32'd0);

    // Forwarding: youngest matching entry wins, r0 never hits
    send(1'b1, 5'd7, 32'd10, 1'b1, 5'd7, 32'd20, aa, ba);
    lk_probe(5'd7, 1'b1, 32'd20);
    lk_probe(5'd0, 1'b0, 32'd0);
    lk_probe(5'd8, 1'b0, 32'd0);
    idle(1);
    lk_probe(5'd7, 1'b1, 32'd20);
    idle(1);
    lk_probe(5'd7, 1'b0, 32'd0);

    idle(2);
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_pending", {29'd0, pending}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
